// File: rtl/instr_fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the program ROM, the control unit and
// the host that starts and stops program runs.
interface instr_fetch_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  // Host side
  logic              start;
  logic              halt;
  logic [ADDR_W-1:0] last_addr;
  logic              busy;
  logic              err;
  logic [15:0]       instr_count;
  logic [ADDR_W-1:0] pc;

  // Program ROM side (one-cycle read latency)
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  // Control unit side
  logic [DATA_W-1:0] din;
  logic              run;
  logic              done;

  // The sequencer drives the ROM address and the control unit.
  modport master (
    input  start, halt, last_addr, mem_rdata, done,
    output mem_addr, din, run, pc, busy, err, instr_count
  );

  // Environment side: host, ROM and control unit.
  modport slave (
    output start, halt, last_addr, mem_rdata, done,
    input  mem_addr, din, run, pc, busy, err, instr_count
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetches instruction words from a synchronous program ROM, hands each word to
// the control unit with a one-cycle active-low run pulse and waits for done
// before moving on. Runs 0..last, supports a graceful halt and flags a control
// unit that never answers.
module instr_fetch_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  instr_fetch_sequencer_if.master  bus
);

  // The timeout counter only has to count the EXEC cycles that precede the
  // last allowed one, i.e. 0..TIMEOUT-1.
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_ISSUE,
    S_EXEC
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              halt_pend_q, halt_pend_d;

  // A halt raised in the same EXEC cycle as done still stops the run.
  logic end_of_run;
  assign end_of_run = (pc_q == last_q) || halt_pend_q || bus.halt;

  // The ROM address always tracks pc; run/busy are decoded from the state.
  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.din         = din_q;
  assign bus.run         = (state_q != S_ISSUE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.err         = err_q;
  assign bus.instr_count = cnt_q;

  // Next-state logic: fetch, capture, issue, then wait for done or timeout.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    last_d      = last_q;
    din_d       = din_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    halt_pend_d = halt_pend_q;

    // Remember a halt request until the current instruction completes.
    if (state_q != S_IDLE && bus.halt) begin
      halt_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // start is only honoured here, so a held start cannot restart a run.
        if (bus.start) begin
          pc_d        = '0;
          last_d      = bus.last_addr;
          err_d       = 1'b0;
          cnt_d       = '0;
          halt_pend_d = 1'b0;
          state_d     = S_FETCH;
        end
      end

      S_FETCH: begin
        // mem_addr already shows pc; the ROM answers next cycle.
        state_d = S_WAIT_MEM;
      end

      S_WAIT_MEM: begin
        din_d   = bus.mem_rdata;
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (bus.done) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (end_of_run) begin
            state_d = S_IDLE;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      last_q      <= '0;
      din_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      last_q      <= last_d;
      din_q       <= din_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // The run pulse is never wider than one cycle.
  assert property (@(posedge clk) disable iff (!reset_n) !bus.run |=> bus.run);

  // pc never runs past the sampled last address.
  assert property (@(posedge clk) disable iff (!reset_n) (state_q != S_IDLE) |-> (pc_q <= last_q));

  // The timeout counter stays within its range while executing.
  assert property (@(posedge clk) disable iff (!reset_n) (state_q == S_EXEC) |-> (tmo_q <= TMO_LAST));

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: a program ROM model, a control unit model
// whose latency follows the opcode in din, a timeline reference model that
// predicts every run pulse and every end of run, and a scoreboard monitor.
module tb_instr_fetch_sequencer;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;
  localparam int ROM_N   = 1 << ADDR_W;

  logic clk;
  logic reset_n;

  instr_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct { int cyc; int addr; logic [DATA_W-1:0] word; } iss_t;
  typedef struct { int cyc; int pc; int cnt; logic err; } fin_t;

  iss_t issue_q[$];
  fin_t end_q[$];

  logic [DATA_W-1:0] rom [0:ROM_N-1];
  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;
  int run_no = 0;
  bit spurious_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous program ROM, one cycle of read latency.
  always @(posedge clk) bus.mem_rdata <= rom[bus.mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Control-unit timing by opcode: MV/MVT answer in EXEC cycle 2, ADD/SUB in
  // cycle 4, anything else never answers.
  function automatic int lat_of(input logic [DATA_W-1:0] w);
    case (w[DATA_W-1 -: 3])
      3'd0, 3'd1: return 2;
      3'd2, 3'd3: return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] mk_word(input int op);
    logic [DATA_W-1:0] w;
    logic [2:0] o;
    o = op[2:0];
    w = DATA_W'($urandom);
    w[DATA_W-1 -: 3] = o;
    return w;
  endfunction

  task automatic fill_rom(input bit all_ops, input bit allow_hang);
    for (int i = 0; i < ROM_N; i++) begin
      int op;
      op = all_ops ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1));
      if (allow_hang && $urandom_range(0, 15) == 0) op = 7;
      rom[i] = mk_word(op);
    end
  endtask

  // Reference model: walks the program as a timeline of relative cycles
  // (cycle 0 = start sampled in IDLE). Each instruction costs 3 cycles of
  // fetch/issue plus its control latency plus the done cycle.
  task automatic model_push(input int base, input int last, input int h, output int end_rel,
                            output int exp_pc, output int exp_cnt, output bit exp_err);
    int t, addr, cnt, lat, d;
    bit fin, err;
    iss_t ei;
    fin_t ef;
    t = 1; addr = 0; cnt = 0; err = 0; fin = 0; end_rel = 0;
    while (!fin) begin
      lat = lat_of(rom[addr]);
      ei.cyc = base + t + 2; ei.addr = addr; ei.word = rom[addr];
      issue_q.push_back(ei);
      if (lat == 0) begin
        err = 1; end_rel = t + 2 + TIMEOUT + 1; fin = 1;
      end else begin
        d = t + 2 + lat;
        cnt++;
        if (addr == last || (h >= 1 && h <= d)) begin
          end_rel = d + 1; fin = 1;
        end else begin
          addr++; t = d + 1;
        end
      end
    end
    ef.cyc = base + end_rel; ef.pc = addr; ef.cnt = cnt; ef.err = err;
    end_q.push_back(ef);
    exp_pc = addr; exp_cnt = cnt; exp_err = err;
  endtask

  // One program run; halt pulses at relative cycle h (-1 = none, 0 = with start).
  task automatic run_prog(input int last, input int h, input bit hold, input bit spur);
    int base, end_rel, epc, ecnt;
    bit eerr, got;
    spurious_en = spur;
    @(negedge clk);
    base = cyc;
    model_push(base, last, h, end_rel, epc, ecnt, eerr);
    bus.start = 1'b1;
    bus.last_addr = ADDR_W'(last);
    bus.halt = (h == 0);
    got = 0;
    for (int t = 1; t <= end_rel + 40 && !got; t++) begin
      @(negedge clk);
      bus.halt = (t == h);
      bus.start = hold && (t < end_rel - 1);
      bus.last_addr = ADDR_W'($urandom);
      if (end_q.size() == 0) got = 1;
    end
    bus.start = 1'b0;
    bus.halt = 1'b0;
    if (!got) begin
      n_vec++; n_mis++;
      $display("FAIL run_end: busy still high after %0d cycles, expected low at cycle %0d", end_rel + 40, end_rel);
      end_q.delete();
    end
    chk("issue_leftover", issue_q.size(), 0);
    issue_q.delete();
    run_no++;
    $display("run %0d: last=%0d halt_at=%0d hold=%0d spur=%0d -> expect pc=%0d count=%0d err=%0d",
             run_no, last, h, hold, spur, epc, ecnt, eerr);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_run"}, bus.run, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_pc"}, bus.pc, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_din"}, bus.din, 0);
    chk({tag, "_count"}, bus.instr_count, 0);
  endtask

  // Control unit model: sees run low in ISSUE, answers after its latency;
  // optionally throws spurious done while it is not executing.
  initial begin : cu
    int cu_cnt, cu_lat;
    bit cu_active;
    cu_active = 0; cu_cnt = 0; cu_lat = 0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        cu_active = 0;
        bus.done = 1'b0;
      end else if (bus.run === 1'b0) begin
        cu_active = 1; cu_cnt = 0; cu_lat = lat_of(bus.din);
        bus.done = 1'b0;
      end else if (cu_active) begin
        cu_cnt++;
        bus.done = (cu_cnt == cu_lat);
        if (bus.done || bus.busy !== 1'b1) cu_active = 0;
      end else begin
        bus.done = spurious_en && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Scoreboard monitor: pops an expectation for every run pulse and every
  // falling edge of busy.
  initial begin : mon
    iss_t ei;
    fin_t ef;
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        busy_prev = 1'b0;
      end else begin
        if (bus.run !== 1'b1) begin
          if (issue_q.size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL run_pulse: run low at cycle %0d with pc %0h, no pulse expected", cyc, bus.pc);
          end else begin
            ei = issue_q.pop_front();
            chk("run_cycle", cyc, ei.cyc);
            chk("issue_pc", bus.pc, ei.addr);
            chk("issue_mem_addr", bus.mem_addr, ei.addr);
            chk("issue_din", bus.din, ei.word);
          end
        end
        if (busy_prev && bus.busy !== 1'b1) begin
          if (end_q.size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL run_end: busy fell at cycle %0d, no end expected", cyc);
          end else begin
            ef = end_q.pop_front();
            chk("end_cycle", cyc, ef.cyc);
            chk("end_pc", bus.pc, ef.pc);
            chk("end_count", bus.instr_count, ef.cnt);
            chk("end_err", bus.err, ef.err);
          end
        end
        busy_prev = (bus.busy === 1'b1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, end_rel, epc, ecnt, lst, h;
    bit eerr;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.last_addr = '0;
    for (int i = 0; i < ROM_N; i++) rom[i] = '0;

    @(posedge clk); #1;
    check_reset("por");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Three MV words, last = 2.
    for (int i = 0; i < 3; i++) rom[i] = mk_word(i % 2);
    run_prog(2, -1, 0, 0);

    // Single ADD.
    rom[0] = mk_word(2);
    run_prog(0, -1, 0, 0);

    // Control unit never answers: timeout, sticky err, cleared by next start.
    rom[0] = mk_word(7);
    run_prog(0, -1, 0, 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", bus.err, 1);
    rom[0] = mk_word(1);
    run_prog(0, -1, 0, 0);

    // Halt during WAIT_MEM of instruction 1.
    for (int i = 0; i < 6; i++) rom[i] = mk_word(0);
    run_prog(5, 7, 0, 0);

    // Start held through the run with spurious done; halt in IDLE with start.
    fill_rom(1, 0);
    run_prog(3, -1, 1, 1);
    run_prog(3, 0, 0, 0);

    // Reset for one cycle in the middle of EXEC.
    spurious_en = 0;
    rom[0] = mk_word(0) | DATA_W'(1);
    rom[1] = mk_word(2) | DATA_W'(1);
    @(negedge clk);
    base = cyc;
    model_push(base, 1, -1, end_rel, epc, ecnt, eerr);
    bus.start = 1'b1;
    bus.last_addr = ADDR_W'(1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset("mid");
    chk("mid_issued", issue_q.size(), 0);
    reset_n = 1'b1;
    issue_q.delete();
    end_q.delete();
    repeat (20) @(negedge clk);
    run_prog(1, -1, 0, 0);

    // Full address space, last = 2^ADDR_W - 1.
    fill_rom(0, 0);
    run_prog(ROM_N - 1, -1, 0, 1);

    // Randomized programs.
    for (int r = 0; r < 30; r++) begin
      fill_rom(1, 1);
      lst = $urandom_range(0, 12);
      h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
      run_prog(lst, h, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
